// File: rtl/cpu_syscall_ctrl.sv
// Syscall sequencing controller for the EX stage: print/exit decode, display-hold stall, halt.
// Optional pause-until-resume on v0=50 is built when SYSCALL_PAUSE_EN is defined.

`ifndef PC_INC_STOP_OR_MASK
`define PC_INC_STOP_OR_MASK 2'b11
`endif

module cpu_syscall_ctrl #(
  parameter int DISPLAY_HOLD_CYCLES = 4,
  parameter int CNT_W               = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             syscall_valid,
  input  logic [31:0]      reg_v0,
  input  logic [31:0]      reg_a0,
  input  logic             resume,
  output logic             stall,
  output logic [1:0]       pc_inc_mask,
  output logic [31:0]      display,
  output logic             display_valid,
  output logic             halted,
  output logic [CNT_W-1:0] syscall_count
);

  localparam int HOLD_W = (DISPLAY_HOLD_CYCLES > 1) ? $clog2(DISPLAY_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT =
    (DISPLAY_HOLD_CYCLES > 0) ? HOLD_W'(DISPLAY_HOLD_CYCLES - 1) : '0;

  localparam logic [31:0] V0_PRINT = 32'd1;
  localparam logic [31:0] V0_EXIT  = 32'd10;
  localparam logic [1:0]  STOP_MASK = `PC_INC_STOP_OR_MASK;

`ifdef SYSCALL_PAUSE_EN
  localparam logic [31:0] V0_PAUSE = 32'd50;
  typedef enum logic [1:0] {IDLE, HOLD, HALT, PAUSE} state_t;
`else
  typedef enum logic [1:0] {IDLE, HOLD, HALT} state_t;
  logic unused_resume;
  assign unused_resume = resume;
`endif

  state_t             state_reg, state_next;
  logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic [31:0]        display_reg, display_next;
  logic               display_valid_reg, display_valid_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               accept;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg         <= IDLE;
      hold_cnt_reg      <= '0;
      display_reg       <= '0;
      display_valid_reg <= 1'b0;
      count_reg         <= '0;
    end else begin
      state_reg         <= state_next;
      hold_cnt_reg      <= hold_cnt_next;
      display_reg       <= display_next;
      display_valid_reg <= display_valid_next;
      count_reg         <= count_next;
    end
  end

  // Only IDLE accepts: stall is low there, so the syscall leaves EX on the accepting edge.
  assign accept = (state_reg == IDLE) && syscall_valid;

  always_comb begin
    state_next         = state_reg;
    hold_cnt_next      = hold_cnt_reg;
    display_next       = display_reg;
    display_valid_next = 1'b0;
    count_next         = count_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (count_reg != {CNT_W{1'b1}}) begin
            count_next = count_reg + CNT_W'(1);
          end
          if (reg_v0 == V0_PRINT) begin
            display_next       = reg_a0;
            display_valid_next = 1'b1;
            if (DISPLAY_HOLD_CYCLES > 0) begin
              state_next    = HOLD;
              hold_cnt_next = HOLD_INIT;
            end
          end else if (reg_v0 == V0_EXIT) begin
            state_next = HALT;
          end
`ifdef SYSCALL_PAUSE_EN
          else if (reg_v0 == V0_PAUSE) begin
            state_next = PAUSE;
          end
`endif
        end
      end
      HOLD: begin
        if (hold_cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          hold_cnt_next = hold_cnt_reg - HOLD_W'(1);
        end
      end
      HALT: begin
        state_next = HALT;
      end
`ifdef SYSCALL_PAUSE_EN
      PAUSE: begin
        if (resume) begin
          state_next = IDLE;
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign stall         = (state_reg != IDLE);
  assign halted        = (state_reg == HALT);
  assign pc_inc_mask   = (state_reg == HALT) ? STOP_MASK : 2'b00;
  assign display       = display_reg;
  assign display_valid = display_valid_reg;
  assign syscall_count = count_reg;

endmodule

// File: tb/tb_cpu_syscall_ctrl.sv
// Scoreboard bench for cpu_syscall_ctrl: a 4-cycle-hold/16-bit-count instance and a
// no-hold/4-bit-count instance for back-to-back accepts and saturation.

`ifndef PC_INC_STOP_OR_MASK
`define PC_INC_STOP_OR_MASK 2'b11
`endif

module tb_cpu_syscall_ctrl;

  localparam int H = 4;
  localparam logic [1:0] STOP_MASK = `PC_INC_STOP_OR_MASK;

  typedef struct packed {
    logic [31:0] disp;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b1;

  logic        a_sv = 1'b0, a_resume = 1'b0;
  logic [31:0] a_v0 = '0, a_a0 = '0;
  logic        a_stall, a_dv, a_halted;
  logic [1:0]  a_mask;
  logic [31:0] a_disp;
  logic [15:0] a_cnt;

  logic        b_sv = 1'b0, b_resume = 1'b0;
  logic [31:0] b_v0 = '0, b_a0 = '0;
  logic        b_stall, b_dv, b_halted;
  logic [1:0]  b_mask;
  logic [31:0] b_disp;
  logic [3:0]  b_cnt;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_syscall_ctrl #(.DISPLAY_HOLD_CYCLES(H), .CNT_W(16)) dut_a (
    .clk(clk), .clr(clr), .syscall_valid(a_sv), .reg_v0(a_v0), .reg_a0(a_a0),
    .resume(a_resume), .stall(a_stall), .pc_inc_mask(a_mask), .display(a_disp),
    .display_valid(a_dv), .halted(a_halted), .syscall_count(a_cnt)
  );

  cpu_syscall_ctrl #(.DISPLAY_HOLD_CYCLES(0), .CNT_W(4)) dut_b (
    .clk(clk), .clr(clr), .syscall_valid(b_sv), .reg_v0(b_v0), .reg_a0(b_a0),
    .resume(b_resume), .stall(b_stall), .pc_inc_mask(b_mask), .display(b_disp),
    .display_valid(b_dv), .halted(b_halted), .syscall_count(b_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!clr && a_dv) begin
          checks++;
          if (q_a.size() == 0) begin
            errors++;
            $display("FAIL a_display_pulse: unexpected pulse display=%0h count=%0d", a_disp, a_cnt);
          end else begin
            ea = q_a.pop_front();
            if (a_disp !== ea.disp || a_cnt !== ea.cnt) begin
              errors++;
              $display("FAIL a_display: got display=%0h count=%0d expected display=%0h count=%0d",
                       a_disp, a_cnt, ea.disp, ea.cnt);
            end else begin
              $display("txn a: display=%0h count=%0d", a_disp, a_cnt);
            end
          end
        end
        if (!clr && b_dv) begin
          checks++;
          if (q_b.size() == 0) begin
            errors++;
            $display("FAIL b_display_pulse: unexpected pulse display=%0h count=%0d", b_disp, b_cnt);
          end else begin
            eb = q_b.pop_front();
            if (b_disp !== eb.disp || b_cnt !== eb.cnt[3:0]) begin
              errors++;
              $display("FAIL b_display: got display=%0h count=%0d expected display=%0h count=%0d",
                       b_disp, b_cnt, eb.disp, eb.cnt[3:0]);
            end else begin
              $display("txn b: display=%0h count=%0d", b_disp, b_cnt);
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'd0, a_stall}, 32'd0);
    chk("rst_mask", {30'd0, a_mask}, 32'd0);
    chk("rst_display", a_disp, 32'd0);
    chk("rst_dv", {31'd0, a_dv}, 32'd0);
    chk("rst_halted", {31'd0, a_halted}, 32'd0);
    chk("rst_count", {16'd0, a_cnt}, 32'd0);
    chk("rst_b_count", {28'd0, b_cnt}, 32'd0);
    clr = 1'b0;
    tick();

    // Print with 4-cycle hold; a0 changes after accept must not reach display
    a_sv = 1'b1; a_v0 = 32'd1; a_a0 = 32'h0000BEEF;
    q_a.push_back('{32'h0000BEEF, 16'd1});
    tick();
    a_sv = 1'b0; a_v0 = 32'd0; a_a0 = 32'hDEAD0000;
    for (int i = 0; i < 5; i++) begin
      chk("hold_stall", {31'd0, a_stall}, (i < H) ? 32'd1 : 32'd0);
      tick();
    end
    chk("print_display", a_disp, 32'h0000BEEF);
    chk("print_count", {16'd0, a_cnt}, 32'd1);

    // syscall_valid held through HOLD: only accepted on first IDLE edge
    a_sv = 1'b1; a_v0 = 32'd1; a_a0 = 32'h00001111;
    q_a.push_back('{32'h00001111, 16'd2});
    tick();
    a_a0 = 32'h00001234;
    repeat (4) tick();
    chk("held_display", a_disp, 32'h00001111);
    chk("held_count", {16'd0, a_cnt}, 32'd2);
    chk("held_stall_idle", {31'd0, a_stall}, 32'd0);
    q_a.push_back('{32'h00001234, 16'd3});
    tick();
    a_sv = 1'b0;
    chk("held_accept_stall", {31'd0, a_stall}, 32'd1);
    chk("held_accept_count", {16'd0, a_cnt}, 32'd3);
    repeat (4) tick();
    chk("held_release", {31'd0, a_stall}, 32'd0);

    // Unknown code: counted only
    a_sv = 1'b1; a_v0 = 32'd7; a_a0 = 32'h77777777;
    tick();
    a_sv = 1'b0;
    chk("unk_stall", {31'd0, a_stall}, 32'd0);
    chk("unk_count", {16'd0, a_cnt}, 32'd4);
    chk("unk_display", a_disp, 32'h00001234);

    // resume outside PAUSE is not remembered
    a_resume = 1'b1;
    tick();
    a_resume = 1'b0;

    // Pause code
    a_sv = 1'b1; a_v0 = 32'd50;
    tick();
    a_sv = 1'b0;
    chk("pause_count", {16'd0, a_cnt}, 32'd5);
`ifdef SYSCALL_PAUSE_EN
    for (int i = 0; i < 3; i++) begin
      chk("pause_stall", {31'd0, a_stall}, 32'd1);
      tick();
    end
    a_resume = 1'b1;
    tick();
    a_resume = 1'b0;
    chk("pause_resume", {31'd0, a_stall}, 32'd0);
`else
    chk("pause_off_stall", {31'd0, a_stall}, 32'd0);
`endif

    // Exit: sticky HALT ignoring syscalls and resume
    a_sv = 1'b1; a_v0 = 32'd10;
    tick();
    a_v0 = 32'd1; a_a0 = 32'h00005555; a_resume = 1'b1;
    chk("exit_halted", {31'd0, a_halted}, 32'd1);
    chk("exit_stall", {31'd0, a_stall}, 32'd1);
    chk("exit_mask", {30'd0, a_mask}, {30'd0, STOP_MASK});
    chk("exit_count", {16'd0, a_cnt}, 32'd6);
    repeat (3) tick();
    chk("halt_sticky", {31'd0, a_halted}, 32'd1);
    chk("halt_mask", {30'd0, a_mask}, {30'd0, STOP_MASK});
    chk("halt_count", {16'd0, a_cnt}, 32'd6);
    chk("halt_display", a_disp, 32'h00001234);
    a_sv = 1'b0; a_resume = 1'b0;

    // Asynchronous clear mid-cycle
    #2;
    clr = 1'b1;
    #1;
    chk("aclr_stall", {31'd0, a_stall}, 32'd0);
    chk("aclr_halted", {31'd0, a_halted}, 32'd0);
    chk("aclr_mask", {30'd0, a_mask}, 32'd0);
    chk("aclr_count", {16'd0, a_cnt}, 32'd0);
    chk("aclr_display", a_disp, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    tick();
    chk("post_clr_stall", {31'd0, a_stall}, 32'd0);

    // No-hold instance: back-to-back prints, then saturation of a 4-bit count
    b_sv = 1'b1; b_v0 = 32'd1; b_a0 = 32'h000000A5;
    q_b.push_back('{32'h000000A5, 16'd1});
    tick();
    chk("b_nohold_stall0", {31'd0, b_stall}, 32'd0);
    b_a0 = 32'h0000005A;
    q_b.push_back('{32'h0000005A, 16'd2});
    tick();
    chk("b_nohold_stall1", {31'd0, b_stall}, 32'd0);
    chk("b_b2b_count", {28'd0, b_cnt}, 32'd2);
    b_v0 = 32'd7;
    repeat (20) tick();
    b_sv = 1'b0;
    chk("b_sat_count", {28'd0, b_cnt}, 32'd15);
    chk("b_sat_stall", {31'd0, b_stall}, 32'd0);
    chk("b_sat_display", b_disp, 32'h0000005A);

    repeat (2) tick();
    chk("a_queue_drained", q_a.size(), 32'd0);
    chk("b_queue_drained", q_b.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
